// File: rtl/mem_cycle_ctrl.sv
// SRAM access sequencer: drives address latch, address-counter clock, output enable,
// write enable and data-bus driver enable for read and write cycles, with configurable
// phase lengths and multi-beat bursts.
// Optional build macro MEM_WAIT_EN adds a mem_wait input that stretches the access phase.
module mem_cycle_ctrl #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned ACCESS_CYC  = 1,
  parameter int unsigned RECOVER_CYC = 1,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned BURST_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [BURST_W-1:0] burst_len,
`ifdef MEM_WAIT_EN
  input  logic               mem_wait,
`endif
  output logic               latch,
  output logic               count,
  output logic               not_oe,
  output logic               not_we,
  output logic               drive_en,
  output logic               reading,
  output logic               writing,
  output logic               busy,
  output logic               done
);

  // Reject phase lengths the timer cannot represent.
  if (SETUP_CYC < 1 || SETUP_CYC > (1 << CNT_W) ||
      ACCESS_CYC < 1 || ACCESS_CYC > (1 << CNT_W) ||
      RECOVER_CYC < 1 || RECOVER_CYC > (1 << CNT_W)) begin : g_bad_cfg
    $error("mem_cycle_ctrl: each *_CYC must be in 1..2**CNT_W");
  end

  // Timer counts down to zero, so it is loaded with length-1.
  localparam logic [CNT_W-1:0]   SetupLd   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]   AccessLd  = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0]   RecoverLd = CNT_W'(RECOVER_CYC - 1);
  localparam logic [CNT_W-1:0]   TimerOne  = CNT_W'(1);
  localparam logic [BURST_W-1:0] BeatOne   = BURST_W'(1);

  typedef enum logic [2:0] {
    StIdle, StLatch, StSetup, StAccess, StHold, StRecover, StDecide
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;   // 1 = write transaction, 0 = read
  logic [BURST_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0]   timer_q, timer_d;

  logic latch_d, count_d, not_oe_d, not_we_d, drive_en_d;
  logic reading_d, writing_d, busy_d, done_d;
  logic access_wait;
  logic same_req;

`ifdef MEM_WAIT_EN
  assign access_wait = mem_wait;
`else
  assign access_wait = 1'b0;
`endif

  // Burst continues only while the own-mode request is high and the other one is low.
  assign same_req = mode_q ? (write && !read) : (read && !write);

  // Next-state, phase timer, beat counter and decoded output values.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    beats_d    = beats_q;
    timer_d    = timer_q;
    latch_d    = 1'b0;
    count_d    = 1'b1;
    not_oe_d   = 1'b1;
    not_we_d   = 1'b1;
    drive_en_d = 1'b0;
    reading_d  = 1'b0;
    writing_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (read ^ write) begin
          state_d = StLatch;
          mode_d  = write;
          beats_d = burst_len;
        end
      end
      StLatch: begin
        latch_d = 1'b1;
        state_d = StSetup;
        timer_d = SetupLd;
      end
      StSetup: begin
        count_d    = 1'b0;
        drive_en_d = mode_q;
        if (timer_q == '0) begin
          state_d = StAccess;
          timer_d = AccessLd;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      StAccess: begin
        count_d    = 1'b0;
        not_oe_d   = mode_q;
        not_we_d   = !mode_q;
        drive_en_d = mode_q;
        if (timer_q != '0) begin
          timer_d = timer_q - TimerOne;
        end else if (!access_wait) begin
          state_d = StHold;
        end
      end
      StHold: begin
        // count returns high here: this is the address-advance edge.
        not_oe_d   = mode_q;
        not_we_d   = !mode_q;
        drive_en_d = mode_q;
        state_d    = StRecover;
        timer_d    = RecoverLd;
      end
      StRecover: begin
        if (timer_q == '0) begin
          state_d = StDecide;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      StDecide: begin
        if (beats_q != '0 && same_req) begin
          beats_d = beats_q - BeatOne;
          state_d = StLatch;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      busy_d    = 1'b1;
      reading_d = !mode_q;
      writing_d = mode_q;
    end
  end

  // State register and registered outputs; reset forces every strobe inactive at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= 1'b0;
      beats_q  <= '0;
      timer_q  <= '0;
      latch    <= 1'b0;
      count    <= 1'b1;
      not_oe   <= 1'b1;
      not_we   <= 1'b1;
      drive_en <= 1'b0;
      reading  <= 1'b0;
      writing  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      beats_q  <= beats_d;
      timer_q  <= timer_d;
      latch    <= latch_d;
      count    <= count_d;
      not_oe   <= not_oe_d;
      not_we   <= not_we_d;
      drive_en <= drive_en_d;
      reading  <= reading_d;
      writing  <= writing_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Self-checking bench for mem_cycle_ctrl: directed scenarios followed by random
// request/burst/reset traffic, compared cycle by cycle against a beat-offset model.
module tb_mem_cycle_ctrl;

  localparam int TS = 2;
  localparam int TA = 3;
  localparam int TR = 2;
  localparam int BW = 3;
  localparam int LAST = TS + TA + TR + 2;      // offset of the decide cycle in a beat
  localparam int BEAT = LAST + 1;
  // Output vector order: {latch, count, not_oe, not_we, drive_en, reading, writing, busy, done}
  localparam logic [8:0] IDLE_OUT = 9'b0_1_1_1_0_0_0_0_0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          mem_wait = 1'b0;
  logic latch, count, not_oe, not_we, drive_en, reading, writing, busy, done;
  logic [8:0] dut_outs;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_cycle_ctrl #(
    .SETUP_CYC  (TS),
    .ACCESS_CYC (TA),
    .RECOVER_CYC(TR),
    .CNT_W      (4),
    .BURST_W    (BW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .burst_len(burst_len),
`ifdef MEM_WAIT_EN
    .mem_wait (mem_wait),
`endif
    .latch    (latch),
    .count    (count),
    .not_oe   (not_oe),
    .not_we   (not_we),
    .drive_en (drive_en),
    .reading  (reading),
    .writing  (writing),
    .busy     (busy),
    .done     (done)
  );

  assign dut_outs = {latch, count, not_oe, not_we, drive_en, reading, writing, busy, done};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: position within the current beat (-1 = idle), outputs derived
  // arithmetically from that offset and registered one cycle later.
  int         pos = -1;
  bit         m_wr = 1'b0;
  int         m_left = 0;
  int         m_beats = 0;
  logic [8:0] exp_o = IDLE_OUT;

  function automatic logic [8:0] model_outs(int p, bit wr, bit dn);
    bit act;
    if (p < 0) return IDLE_OUT;
    act = (p >= TS + 1) && (p <= TS + TA + 1);
    return {p == 0, !(p >= 1 && p <= TS + TA), !(act && !wr), !(act && wr),
            wr && p >= 1 && p <= TS + TA + 1, !wr, wr, 1'b1, dn};
  endfunction

  always @(posedge clk) begin
    bit cont, wt;
`ifdef MEM_WAIT_EN
    wt = mem_wait;
`else
    wt = 1'b0;
`endif
    if (reset) begin
      exp_o  = IDLE_OUT;
      pos    = -1;
      m_wr   = 1'b0;
      m_left = 0;
    end else begin
      cont  = (pos == LAST) && (m_left != 0) &&
              (m_wr ? (write && !read) : (read && !write));
      exp_o = model_outs(pos, m_wr, pos == LAST && !cont);
      if (pos < 0) begin
        if (read ^ write) begin
          pos = 0; m_wr = write; m_left = int'(burst_len); m_beats = 1;
        end
      end else if (pos == LAST) begin
        if (cont) begin
          pos = 0; m_left--; m_beats++;
        end else begin
          pos = -1;
        end
      end else if (!(pos == TS + TA && wt)) begin
        pos++;
      end
    end
  end

  // Per-cycle comparison and count-rise tally per transaction.
  bit chk_en = 1'b0;
  int rises = 0;
  logic prev_count = 1'b1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("outs{l,c,oe,we,de,rd,wr,bz,dn}", int'(dut_outs), int'(exp_o));
      if (count && !prev_count) rises++;
      if (exp_o[0]) begin
        check("count_rises_per_txn", rises, m_beats);
        rises = 0;
      end else if (!exp_o[1]) begin
        rises = 0;
      end
    end
    prev_count = count;
  end

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit && !exp_o[0]; i++) @(negedge clk);
    if (i >= limit) check("done_timeout", 1, 0);
  endtask

  initial begin
    int hold;
    repeat (2) @(negedge clk);
    check("reset_state", int'(dut_outs), int'(IDLE_OUT));
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);

    // Single read, request for one cycle.
    read = 1'b1; burst_len = 0;
    @(negedge clk);
    read = 1'b0;
    wait_done(BEAT + 4);
    @(negedge clk);
    check("idle_after_read", int'(busy), 0);

    // Write held through a 3-beat burst.
    write = 1'b1; burst_len = 2;
    wait_done(4 * BEAT);
    write = 1'b0;
    repeat (2) @(negedge clk);

    // Both requests high: no transaction.
    read = 1'b1; write = 1'b1;
    repeat (5) @(negedge clk);
    check("both_high_busy", int'(busy), 0);
    read = 1'b0; write = 1'b0;
    @(negedge clk);

    // Read burst of 4 dropped during beat 2.
    read = 1'b1; burst_len = 3;
    repeat (BEAT + 3) @(negedge clk);
    read = 1'b0;
    wait_done(2 * BEAT);
    repeat (2) @(negedge clk);

    // Reset during the access phase of a read, then a clean read.
    read = 1'b1; burst_len = 0;
    repeat (TS + 3) @(negedge clk);
    check("mid_read_strobe", int'(not_oe), 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outs", int'(dut_outs), int'(IDLE_OUT));
    reset = 1'b0; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    wait_done(BEAT + 4);
    @(negedge clk);

    // Random traffic.
    hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (hold == 0) begin
        int op;
        op = $urandom_range(0, 9);
        read      = (op <= 3) || (op == 8);
        write     = (op >= 4 && op <= 8);
        burst_len = BW'($urandom_range(0, (1 << BW) - 1));
        hold      = $urandom_range(1, 3 * BEAT);
      end else begin
        hold--;
      end
      mem_wait = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    reset = 1'b0; read = 1'b0; write = 1'b0; mem_wait = 1'b0;
    repeat (2 * BEAT * (1 << BW)) @(negedge clk);
    check("final_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
